// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: one-outstanding req/gnt/rvalid fetcher
// feeding a DEPTH-entry {pc, instr} FIFO, with redirect flush and response discard.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     IWIDTH    = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     ADDR_STEP = 1,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [IWIDTH-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              instr_valid,
    output logic [IWIDTH-1:0] instr,
    output logic [XLEN-1:0]   instr_pc,
    input  logic              instr_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    logic [IWIDTH-1:0] fifo_instr [DEPTH];
    logic [XLEN-1:0]   fifo_pc    [DEPTH];
    logic              push, pop, full;

    assign full        = (count_q == CW'(DEPTH));
    assign instr_valid = (count_q != '0);
    assign instr       = fifo_instr[rptr_q];
    assign instr_pc    = fifo_pc[rptr_q];
    assign imem_addr   = fetch_pc_q;
    assign pop         = instr_valid & instr_ready & ~redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        push       = 1'b0;
        imem_req   = 1'b0;
        if (redirect) begin
            // A response still owed by memory must be swallowed before fetching again.
            fetch_pc_d = redirect_pc;
            case (state_q)
                S_WAIT, S_DISCARD: state_d = imem_rvalid ? S_FETCH : S_DISCARD;
                default:           state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    imem_req = ~full & ~reset;
                    if (imem_req && imem_gnt) begin
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + XLEN'(ADDR_STEP);
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        push    = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr[wptr_q] <= imem_rdata;
            fifo_pc[wptr_q]    <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default 32-bit word-addressed instance plus an
// 8-bit byte-addressed instance for address wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    logic        n_req, n_gnt, n_rvalid, n_redirect, n_valid, n_ready;
    logic [7:0]  n_addr, n_redirect_pc, n_instr_pc;
    logic [31:0] n_rdata, n_instr;

    int tests = 0;
    int fails = 0;

    logic        pend;
    logic [31:0] pend_addr;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .IWIDTH(32), .DEPTH(4), .ADDR_STEP(1), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    fetch_unit #(.XLEN(8), .IWIDTH(32), .DEPTH(4), .ADDR_STEP(4), .RESET_PC(8'h0)) dut_n (
        .clk(clk), .reset(reset),
        .imem_req(n_req), .imem_addr(n_addr), .imem_gnt(n_gnt),
        .imem_rvalid(n_rvalid), .imem_rdata(n_rdata),
        .redirect(n_redirect), .redirect_pc(n_redirect_pc),
        .instr_valid(n_valid), .instr(n_instr), .instr_pc(n_instr_pc),
        .instr_ready(n_ready)
    );

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Memory model: grants every request, answers one cycle after the grant.
    task automatic tick();
        logic        issue;
        logic [31:0] a;
        imem_gnt    = 1'b1;
        imem_rvalid = pend;
        imem_rdata  = pend ? dat(pend_addr) : 32'h0;
        #1;
        issue = imem_req & imem_gnt;
        a     = imem_addr;
        clk_step();
        pend        = issue;
        pend_addr   = a;
        imem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        n_gnt = 1'b0; n_rvalid = 1'b0; n_rdata = '0; n_redirect = 1'b0;
        n_redirect_pc = '0; n_ready = 1'b0;
        pend = 1'b0; pend_addr = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_gnt = 1'b1;
        @(negedge clk);
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req_during: got %b expected 0", imem_req); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h expected 0", instr); end
        tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
        do_reset();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(k / 2)) begin fails++; $display("FAIL stream_req k=%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, k / 2); end
                if (k >= 2) begin
                    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'(k / 2 - 1) || instr !== dat(32'(k / 2 - 1))) begin fails++; $display("FAIL stream_head k=%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", k, instr_valid, instr_pc, instr, k / 2 - 1, dat(32'(k / 2 - 1))); end
                end else begin
                    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stream_first_valid: got %b expected 0", instr_valid); end
                end
            end else begin
                tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL stream_wait k=%0d: got req=%b v=%b expected req=0 v=0", k, imem_req, instr_valid); end
            end
            tick();
        end
    endtask

    task automatic test_full();
        logic [31:0] pops_pc[$];
        logic [31:0] pops_in[$];
        logic        seen;
        logic [31:0] first_addr;
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 3; k++) begin
            tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin fails++; $display("FAIL full_stall k=%0d: got req=%b v=%b pc=%h expected req=0 v=1 pc=0", k, imem_req, instr_valid, instr_pc); end
            tick();
        end
        instr_ready = 1'b1;
        seen = 1'b0;
        first_addr = '1;
        for (int k = 0; k < 12; k++) begin
            if (instr_valid) begin
                pops_pc.push_back(instr_pc);
                pops_in.push_back(instr);
            end
            if (imem_req && !seen) begin
                seen = 1'b1;
                first_addr = imem_addr;
            end
            tick();
        end
        tests++; if (pops_pc.size() < 4) begin fails++; $display("FAIL full_pop_count: got %0d expected >=4", pops_pc.size()); end
        for (int i = 0; i < 4 && i < pops_pc.size(); i++) begin
            tests++; if (pops_pc[i] !== 32'(i) || pops_in[i] !== dat(32'(i))) begin fails++; $display("FAIL full_pop_order i=%0d: got pc=%h ins=%h expected pc=%h ins=%h", i, pops_pc[i], pops_in[i], i, dat(32'(i))); end
        end
        tests++; if (first_addr !== 32'h4) begin fails++; $display("FAIL full_resume_addr: got %h expected 4", first_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        instr_ready = 1'b1;
        imem_gnt = 1'b1;
        clk_step();
        imem_gnt = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rdw_req_redirect: got %b expected 0", imem_req); end
        clk_step();
        redirect = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD;
        #1;
        tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL rdw_discard: got req=%b v=%b expected req=0 v=0", imem_req, instr_valid); end
        clk_step();
        imem_rvalid = 1'b0;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL rdw_restart: got v=%b req=%b addr=%h expected v=0 req=1 addr=40", instr_valid, imem_req, imem_addr); end
        clk_step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat(32'h40);
        clk_step();
        imem_rvalid = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== dat(32'h40)) begin fails++; $display("FAIL rdw_new_head: got v=%b pc=%h ins=%h expected v=1 pc=40 ins=%h", instr_valid, instr_pc, instr, dat(32'h40)); end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        for (int k = 0; k < 7; k++) tick();
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || pend !== 1'b1) begin fails++; $display("FAIL rdp_setup: got v=%b pc=%h pend=%b expected v=1 pc=0 pend=1", instr_valid, instr_pc, pend); end
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL rdp_flush: got v=%b req=%b addr=%h expected v=0 req=1 addr=100", instr_valid, imem_req, imem_addr); end
        tick();
        tick();
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== dat(32'h100)) begin fails++; $display("FAIL rdp_new_head: got v=%b pc=%h ins=%h expected v=1 pc=100 ins=%h", instr_valid, instr_pc, instr, dat(32'h100)); end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] exp_a [3];
        exp_a = '{8'hFC, 8'h00, 8'h04};
        do_reset();
        n_ready = 1'b1;
        n_redirect = 1'b1; n_redirect_pc = 8'hFC;
        #1;
        tests++; if (n_req !== 1'b0) begin fails++; $display("FAIL wrap_req_redirect: got %b expected 0", n_req); end
        clk_step();
        n_redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (n_req !== 1'b1 || n_addr !== exp_a[i]) begin fails++; $display("FAIL wrap_addr i=%0d: got req=%b addr=%h expected req=1 addr=%h", i, n_req, n_addr, exp_a[i]); end
            n_gnt = 1'b1;
            clk_step();
            n_gnt = 1'b0; n_rvalid = 1'b1; n_rdata = 32'(i) + 32'h77;
            clk_step();
            n_rvalid = 1'b0;
            tests++; if (n_valid !== 1'b1 || n_instr_pc !== exp_a[i] || n_instr !== 32'(i) + 32'h77) begin fails++; $display("FAIL wrap_head i=%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", i, n_valid, n_instr_pc, n_instr, exp_a[i], 32'(i) + 32'h77); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        tests++; if (instr_valid !== 1'b1 || pend !== 1'b1 || instr_pc !== 32'h0) begin fails++; $display("FAIL areset_setup: got v=%b pend=%b pc=%h expected v=1 pend=1 pc=0", instr_valid, pend, instr_pc); end
        #3;
        reset = 1'b1;
        #1;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL areset_immediate: got v=%b req=%b expected v=0 req=0", instr_valid, imem_req); end
        tests++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL areset_storage: got ins=%h pc=%h expected 0 0", instr, instr_pc); end
        pend = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin fails++; $display("FAIL areset_restart: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", imem_req, imem_addr, instr_valid); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_pop();
        test_addr_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
